// File: rtl/hazard_forward_ctrl.sv
// hazard_forward_ctrl
//   Pipeline hazard controller for the 5-stage core. Produces the EX-stage
//   forwarding selects and sequences the stalls that follow a load-use hazard
//   and the flushes that follow a branch resolved taken in MEM.
//
// Ports
//   clock, reset            rising-edge clock, synchronous active-high reset
//   rs_id, rt_id            source fields of the instruction in ID
//   rs_ex, rt_ex, rd_ex     sources and destination of the instruction in EX
//   memread_ex              instruction in EX is a load
//   rd_mem, regwrite_mem    destination / write enable of the instruction in MEM
//   rd_wb, regwrite_wb      destination / write enable of the instruction in WB
//   branch_taken_mem        branch in MEM resolved taken
//   forwardA, forwardB      forwarding selects: 10 MEM, 01 WB, 00 register file
//   pc_write, ifid_write    PC / IF/ID load enables
//   idex_bubble             zero the ID/EX control fields
//   ifid_flush, idex_flush, exmem_flush   pipeline register clears
//   state                   controller state: 00 RUN, 01 STALL, 10 FLUSH
//
// Optional build macro HAZARD_STATS_EN adds saturating 16-bit counters
//   stall_count, flush_count and fwd_count.
//
// Parameters
//   LOAD_STALL_CYCLES  bubbles per load-use hazard, 1..15
//   CNT_W              stall counter width, 2**CNT_W > LOAD_STALL_CYCLES

module hazard_forward_ctrl #(
  parameter int unsigned LOAD_STALL_CYCLES = 1,
  parameter int unsigned CNT_W             = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [4:0] rs_id,
  input  logic [4:0] rt_id,
  input  logic [4:0] rs_ex,
  input  logic [4:0] rt_ex,
  input  logic [4:0] rd_ex,
  input  logic       memread_ex,
  input  logic [4:0] rd_mem,
  input  logic       regwrite_mem,
  input  logic [4:0] rd_wb,
  input  logic       regwrite_wb,
  input  logic       branch_taken_mem,
  output logic [1:0] forwardA,
  output logic [1:0] forwardB,
  output logic       pc_write,
  output logic       ifid_write,
  output logic       idex_bubble,
  output logic       ifid_flush,
  output logic       idex_flush,
  output logic       exmem_flush,
  output logic [1:0] state
`ifdef HAZARD_STATS_EN
  ,
  output logic [15:0] stall_count,
  output logic [15:0] flush_count,
  output logic [15:0] fwd_count
`endif
);

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    STALL = 2'b01,
    FLUSH = 2'b10
  } stateT;

  localparam logic [CNT_W-1:0] STALL_RELOAD = CNT_W'(LOAD_STALL_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  stateT            curState;
  stateT            nextState;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cntNext;
  logic             loadUse;

  assign state = curState;

  // Forwarding select: MEM result has priority over WB, register 0 never forwards
  function automatic logic [1:0] fwdSel(
    input logic [4:0] src,
    input logic       wrMem,
    input logic [4:0] rdMem,
    input logic       wrWb,
    input logic [4:0] rdWb
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (wrMem && (rdMem != 5'd0) && (rdMem == src)) begin
      sel = 2'b10;
    end else if (wrWb && (rdWb != 5'd0) && (rdWb == src)) begin
      sel = 2'b01;
    end
    return sel;
  endfunction

  always_comb begin
    forwardA = fwdSel(rs_ex, regwrite_mem, rd_mem, regwrite_wb, rd_wb);
    forwardB = fwdSel(rt_ex, regwrite_mem, rd_mem, regwrite_wb, rd_wb);
  end

  // Load in EX whose destination feeds the instruction in ID
  assign loadUse = memread_ex && (rd_ex != 5'd0) && ((rd_ex == rs_id) || (rd_ex == rt_id));

  // State register and stall counter
  always_ff @(posedge clock) begin
    if (reset) begin
      curState <= RUN;
      cnt      <= '0;
    end else begin
      curState <= nextState;
      cnt      <= cntNext;
    end
  end

  // Next-state and Mealy stall/flush outputs
  always_comb begin
    nextState   = curState;
    cntNext     = cnt;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_bubble = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;

    case (curState)
      RUN: begin
        if (branch_taken_mem) begin
          ifid_flush  = 1'b1;
          idex_flush  = 1'b1;
          exmem_flush = 1'b1;
          nextState   = FLUSH;
          cntNext     = '0;
        end else if (loadUse) begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_bubble = 1'b1;
          // A single bubble needs no extra state: the bubble itself clears memread_ex
          if (LOAD_STALL_CYCLES > 1) begin
            cntNext   = STALL_RELOAD;
            nextState = STALL;
          end
        end
      end

      STALL: begin
        if (branch_taken_mem) begin
          ifid_flush  = 1'b1;
          idex_flush  = 1'b1;
          exmem_flush = 1'b1;
          nextState   = FLUSH;
          cntNext     = '0;
        end else begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_bubble = 1'b1;
          cntNext     = cnt - CNT_ONE;
          if (cnt == CNT_ONE) begin
            nextState = RUN;
          end
        end
      end

      FLUSH: begin
        // ID holds a squashed slot, so a load-use match here is spurious
        if (branch_taken_mem) begin
          ifid_flush  = 1'b1;
          idex_flush  = 1'b1;
          exmem_flush = 1'b1;
          cntNext     = '0;
        end else begin
          nextState = RUN;
        end
      end

      default: begin
        nextState = RUN;
        cntNext   = '0;
      end
    endcase

    // Hold the whole pipeline quiet while reset is high
    if (reset) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
    end
  end

`ifdef HAZARD_STATS_EN
  // Saturating event counters
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_count <= '0;
      flush_count <= '0;
      fwd_count   <= '0;
    end else begin
      if (idex_bubble && (stall_count != 16'hFFFF)) begin
        stall_count <= stall_count + 16'd1;
      end
      if (exmem_flush && (flush_count != 16'hFFFF)) begin
        flush_count <= flush_count + 16'd1;
      end
      if (((forwardA != 2'b00) || (forwardB != 2'b00)) && (fwd_count != 16'hFFFF)) begin
        fwd_count <= fwd_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// tb_hazard_forward_ctrl
//   Drives two controllers (1-bubble and 3-bubble builds) from the same
//   pipeline inputs and compares every output, every cycle, against a
//   reference that tracks "bubbles still owed" and "previous cycle was a flush".

module tb_hazard_forward_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic [4:0] rs_id, rt_id, rs_ex, rt_ex, rd_ex, rd_mem, rd_wb;
  logic       memread_ex, regwrite_mem, regwrite_wb, branch_taken_mem;

  logic [1:0] fA [2];
  logic [1:0] fB [2];
  logic [1:0] st [2];
  logic       pcW [2];
  logic       ifW [2];
  logic       bub [2];
  logic       ifF [2];
  logic       idF [2];
  logic       exF [2];
`ifdef HAZARD_STATS_EN
  logic [15:0] sCnt [2];
  logic [15:0] fCnt [2];
  logic [15:0] wCnt [2];
`endif

  always #5 clock = ~clock;

  hazard_forward_ctrl #(.LOAD_STALL_CYCLES(1), .CNT_W(4)) dut1 (
    .clock(clock), .reset(reset),
    .rs_id(rs_id), .rt_id(rt_id), .rs_ex(rs_ex), .rt_ex(rt_ex), .rd_ex(rd_ex),
    .memread_ex(memread_ex), .rd_mem(rd_mem), .regwrite_mem(regwrite_mem),
    .rd_wb(rd_wb), .regwrite_wb(regwrite_wb), .branch_taken_mem(branch_taken_mem),
    .forwardA(fA[0]), .forwardB(fB[0]), .pc_write(pcW[0]), .ifid_write(ifW[0]),
    .idex_bubble(bub[0]), .ifid_flush(ifF[0]), .idex_flush(idF[0]),
    .exmem_flush(exF[0]), .state(st[0])
`ifdef HAZARD_STATS_EN
    , .stall_count(sCnt[0]), .flush_count(fCnt[0]), .fwd_count(wCnt[0])
`endif
  );

  hazard_forward_ctrl #(.LOAD_STALL_CYCLES(3), .CNT_W(4)) dut3 (
    .clock(clock), .reset(reset),
    .rs_id(rs_id), .rt_id(rt_id), .rs_ex(rs_ex), .rt_ex(rt_ex), .rd_ex(rd_ex),
    .memread_ex(memread_ex), .rd_mem(rd_mem), .regwrite_mem(regwrite_mem),
    .rd_wb(rd_wb), .regwrite_wb(regwrite_wb), .branch_taken_mem(branch_taken_mem),
    .forwardA(fA[1]), .forwardB(fB[1]), .pc_write(pcW[1]), .ifid_write(ifW[1]),
    .idex_bubble(bub[1]), .ifid_flush(ifF[1]), .idex_flush(idF[1]),
    .exmem_flush(exF[1]), .state(st[1])
`ifdef HAZARD_STATS_EN
    , .stall_count(sCnt[1]), .flush_count(fCnt[1]), .fwd_count(wCnt[1])
`endif
  );

  int nChecks = 0;
  int nPass   = 0;

  // Reference state per build
  int bubbles [2] = '{1, 3};
  int owed    [2] = '{0, 0};
  bit inFlush [2] = '{1'b0, 1'b0};
  bit valid       = 1'b0;
`ifdef HAZARD_STATS_EN
  int mStall [2] = '{0, 0};
  int mFlush [2] = '{0, 0};
  int mFwd   [2] = '{0, 0};
`endif

  task automatic checkVal(input string tag, input logic [15:0] got, input logic [15:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic [1:0] refFwd(input logic [4:0] src);
    if (regwrite_mem && rd_mem != 0 && rd_mem == src) return 2'b10;
    if (regwrite_wb && rd_wb != 0 && rd_wb == src) return 2'b01;
    return 2'b00;
  endfunction

  task automatic idle();
    reset = 1'b0; rs_id = 0; rt_id = 0; rs_ex = 0; rt_ex = 0; rd_ex = 0;
    rd_mem = 0; rd_wb = 0; memread_ex = 0; regwrite_mem = 0; regwrite_wb = 0;
    branch_taken_mem = 0;
  endtask

  // Check this cycle's outputs, advance the reference, then cross one clock edge
  task automatic runCycle();
    bit lu, expPc, expIf, expBub, expFl;
    logic [1:0] eA, eB, eSt;
    #1;
    lu = memread_ex && rd_ex != 0 && (rd_ex == rs_id || rd_ex == rt_id);
    eA = refFwd(rs_ex);
    eB = refFwd(rt_ex);
    for (int d = 0; d < 2; d++) begin
      eSt = inFlush[d] ? 2'b10 : (owed[d] > 0 ? 2'b01 : 2'b00);
      if (reset) begin
        expPc = 0; expIf = 0; expBub = 1; expFl = 1;
      end else if (branch_taken_mem) begin
        expPc = 1; expIf = 1; expBub = 0; expFl = 1;
      end else if (owed[d] > 0 || (!inFlush[d] && lu)) begin
        expPc = 0; expIf = 0; expBub = 1; expFl = 0;
      end else begin
        expPc = 1; expIf = 1; expBub = 0; expFl = 0;
      end
      checkVal($sformatf("n%0d forwardA", bubbles[d]), 16'(fA[d]), 16'(eA));
      checkVal($sformatf("n%0d forwardB", bubbles[d]), 16'(fB[d]), 16'(eB));
      checkVal($sformatf("n%0d pc_write", bubbles[d]), 16'(pcW[d]), 16'(expPc));
      checkVal($sformatf("n%0d ifid_write", bubbles[d]), 16'(ifW[d]), 16'(expIf));
      checkVal($sformatf("n%0d idex_bubble", bubbles[d]), 16'(bub[d]), 16'(expBub));
      checkVal($sformatf("n%0d ifid_flush", bubbles[d]), 16'(ifF[d]), 16'(expFl));
      checkVal($sformatf("n%0d idex_flush", bubbles[d]), 16'(idF[d]), 16'(expFl));
      checkVal($sformatf("n%0d exmem_flush", bubbles[d]), 16'(exF[d]), 16'(expFl));
      if (valid) checkVal($sformatf("n%0d state", bubbles[d]), 16'(st[d]), 16'(eSt));
`ifdef HAZARD_STATS_EN
      if (valid) begin
        checkVal($sformatf("n%0d stall_count", bubbles[d]), sCnt[d], 16'(mStall[d]));
        checkVal($sformatf("n%0d flush_count", bubbles[d]), fCnt[d], 16'(mFlush[d]));
        checkVal($sformatf("n%0d fwd_count", bubbles[d]), wCnt[d], 16'(mFwd[d]));
      end
      if (reset) begin
        mStall[d] = 0; mFlush[d] = 0; mFwd[d] = 0;
      end else begin
        if (expBub && mStall[d] < 65535) mStall[d]++;
        if (expFl && mFlush[d] < 65535) mFlush[d]++;
        if ((eA != 0 || eB != 0) && mFwd[d] < 65535) mFwd[d]++;
      end
`endif
      if (reset) begin
        owed[d] = 0; inFlush[d] = 0;
      end else if (branch_taken_mem) begin
        owed[d] = 0; inFlush[d] = 1;
      end else if (owed[d] > 0) begin
        owed[d]--;
      end else if (inFlush[d]) begin
        inFlush[d] = 0;
      end else if (lu) begin
        owed[d] = bubbles[d] - 1;
      end
    end
    if (reset) valid = 1'b1;
    @(posedge clock);
    #1;
  endtask

  initial begin
    idle();
    reset = 1;
    runCycle();
    runCycle();
    idle();
    runCycle();

    // Forwarding priority MEM > WB > none
    rs_ex = 5; rt_ex = 5; rd_mem = 5; regwrite_mem = 1; rd_wb = 5; regwrite_wb = 1;
    runCycle();
    regwrite_mem = 0;
    runCycle();
    rd_mem = 0; rd_wb = 0;
    runCycle();
    idle();

    // Load-use held for one cycle, then removed by the bubble
    memread_ex = 1; rd_ex = 3; rt_id = 3;
    runCycle();
    idle();
    runCycle(); runCycle(); runCycle(); runCycle();

    // Load-use held continuously
    memread_ex = 1; rd_ex = 3; rt_id = 3;
    for (int i = 0; i < 5; i++) runCycle();
    idle();
    runCycle(); runCycle(); runCycle();

    // Branch on the second stall cycle
    memread_ex = 1; rd_ex = 7; rs_id = 7;
    runCycle();
    branch_taken_mem = 1;
    runCycle();
    branch_taken_mem = 0;
    runCycle();
    runCycle();
    runCycle();
    idle();
    runCycle(); runCycle(); runCycle();

    // Reset in the middle of a stall
    memread_ex = 1; rd_ex = 9; rs_id = 9;
    runCycle();
    idle();
    runCycle();
    reset = 1;
    runCycle();
    runCycle();
    reset = 0;
    runCycle();
    runCycle();

    // Register 0 never hazards or forwards
    memread_ex = 1; rd_ex = 0; rs_id = 0;
    regwrite_mem = 1; rd_mem = 0; rs_ex = 0;
    runCycle();
    idle();
    runCycle();

    // Random traffic over a small register range so matches are frequent
    for (int i = 0; i < 600; i++) begin
      reset            = ($urandom_range(0, 39) == 0);
      rs_id            = 5'($urandom_range(0, 3));
      rt_id            = 5'($urandom_range(0, 3));
      rs_ex            = 5'($urandom_range(0, 3));
      rt_ex            = 5'($urandom_range(0, 3));
      rd_ex            = 5'($urandom_range(0, 3));
      rd_mem           = 5'($urandom_range(0, 3));
      rd_wb            = 5'($urandom_range(0, 3));
      memread_ex       = 1'($urandom_range(0, 1));
      regwrite_mem     = 1'($urandom_range(0, 1));
      regwrite_wb      = 1'($urandom_range(0, 1));
      branch_taken_mem = ($urandom_range(0, 7) == 0);
      runCycle();
    end

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
